// File: rtl/wb_pkg.sv
// Shared definitions for the write-back unit: FSM state codes, load-size
// codes, bank write-enable polarity and the hard-wired zero register.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10
    } ld_size_e;

    // Bank write enable is active-low.
    localparam logic       REG_WR_ACTIVE = 1'b0;
    // Register 0 is never written.
    localparam logic [4:0] REG_ZERO      = 5'd0;

    // Drive level of the active-low write enable for a given write request.
    function automatic logic reg_wr_level(input logic do_write);
        return do_write ? REG_WR_ACTIVE : ~REG_WR_ACTIVE;
    endfunction

endpackage

// File: rtl/writeback_unit_load_extender.sv
// Narrows load data to byte/half/word and sign- or zero-extends it.
// Purely combinational; only used when LOAD_EXT_EN is defined.
module load_extender
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_size,
    input  logic              i_sign,
    output logic [DATA_W-1:0] o_data
);

    logic w_hi_bit;

    // Select the narrowed field and fill the upper bits with sign or zero.
    always_comb begin
        o_data   = i_data;
        w_hi_bit = 1'b0;
        case (i_size)
            LD_HALF: begin
                w_hi_bit = i_sign & i_data[15];
                o_data   = {{(DATA_W-16){w_hi_bit}}, i_data[15:0]};
            end
            LD_BYTE: begin
                w_hi_bit = i_sign & i_data[7];
                o_data   = {{(DATA_W-8){w_hi_bit}}, i_data[7:0]};
            end
            default: begin
                // Word, and the unused size code 2'b11, pass through.
                w_hi_bit = 1'b0;
                o_data   = i_data;
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: accepts retiring instructions, waits (bounded) for load
// data and drives the register-bank write port plus a one-entry bypass.
// Optional feature macro: LOAD_EXT_EN (byte/half load narrowing + extension).
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_sel_mem,
    input  logic              in_wen,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_sign,
    input  logic [DATA_W-1:0] res_alu,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] DIR_WRA,
    output logic [DATA_W-1:0] DI,
    output logic              REG_WR,
    output logic              fwd_valid,
    output logic              err_timeout
);

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    wb_state_e          r_state;
    wb_state_e          w_state_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic [ADDR_W-1:0]  r_dir_wra;
    logic [ADDR_W-1:0]  w_dir_wra_nxt;
    logic [DATA_W-1:0]  r_di;
    logic [DATA_W-1:0]  w_di_nxt;
    logic               r_reg_wr;
    logic               w_reg_wr_nxt;
    logic               r_fwd_valid;
    logic               r_err;
    logic               w_err_nxt;
    logic [ADDR_W-1:0]  r_dest;
    logic [ADDR_W-1:0]  w_dest_nxt;
    logic               r_wen_eff;
    logic               w_wen_eff_nxt;

    logic               w_accept;
    logic               w_in_wen_eff;
    logic [DATA_W-1:0]  w_ld_data;

    assign in_ready     = (r_state == ST_IDLE) | (r_state == ST_WRITE);
    assign w_accept     = in_valid & in_ready;
    assign w_in_wen_eff = in_wen & (in_dest != ADDR_W'(REG_ZERO));

`ifdef LOAD_EXT_EN
    logic [1:0] r_ld_size;
    logic       r_ld_sign;

    // Hold the load format of the accepted instruction until its data arrives.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_ld_size <= 2'b00;
            r_ld_sign <= 1'b0;
        end else if (w_accept) begin
            r_ld_size <= in_ld_size;
            r_ld_sign <= in_ld_sign;
        end else begin
            r_ld_size <= r_ld_size;
            r_ld_sign <= r_ld_sign;
        end
    end

    load_extender #(.DATA_W(DATA_W)) u_load_extender (
        .i_data (mem_rdata),
        .i_size (r_ld_size),
        .i_sign (r_ld_sign),
        .o_data (w_ld_data)
    );
`else
    // Load format fields have no effect in this build.
    logic w_unused_ld;
    assign w_unused_ld = ^{in_ld_size, in_ld_sign};
    assign w_ld_data   = mem_rdata;
`endif

    // Next-state and next-output decode for the write-back FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_dir_wra_nxt = r_dir_wra;
        w_di_nxt      = r_di;
        w_reg_wr_nxt  = ~REG_WR_ACTIVE;
        w_err_nxt     = r_err;
        w_dest_nxt    = r_dest;
        w_wen_eff_nxt = r_wen_eff;
        case (r_state)
            ST_IDLE, ST_WRITE: begin
                if (w_accept) begin
                    w_dest_nxt    = in_dest;
                    w_wen_eff_nxt = w_in_wen_eff;
                    if (in_sel_mem) begin
                        w_state_nxt = ST_WAIT_MEM;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt   = ST_WRITE;
                        w_dir_wra_nxt = in_dest;
                        w_di_nxt      = res_alu;
                        w_reg_wr_nxt  = reg_wr_level(w_in_wen_eff);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                // Data arriving on the last counted cycle still wins.
                if (mem_valid) begin
                    w_state_nxt   = ST_WRITE;
                    w_dir_wra_nxt = r_dest;
                    w_di_nxt      = w_ld_data;
                    w_reg_wr_nxt  = reg_wr_level(r_wen_eff);
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State, counter, holding and output registers.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_dir_wra   <= '0;
            r_di        <= '0;
            r_reg_wr    <= ~REG_WR_ACTIVE;
            r_fwd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_dest      <= '0;
            r_wen_eff   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dir_wra   <= w_dir_wra_nxt;
            r_di        <= w_di_nxt;
            r_reg_wr    <= w_reg_wr_nxt;
            r_fwd_valid <= (w_reg_wr_nxt == REG_WR_ACTIVE);
            r_err       <= w_err_nxt;
            r_dest      <= w_dest_nxt;
            r_wen_eff   <= w_wen_eff_nxt;
        end
    end

    assign DIR_WRA     = r_dir_wra;
    assign DI          = r_di;
    assign REG_WR      = r_reg_wr;
    assign fwd_valid   = r_fwd_valid;
    assign err_timeout = r_err;

endmodule
